serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that sequences one shared `full_adder` instance across a WIDTH-bit operand pair, LSB first, one bit per clock.
- Holds the operand and result shift registers, a carry flip-flop and a bit counter.
- Provides a start/busy/done handshake so datapath control can request multi-bit sums without a ripple-carry chain.
- Instantiates exactly one `full_adder`; no other adder logic is permitted.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk      input   1      system clock, rising-edge active
- rst_n    input   1      asynchronous, active-low reset
- start    input   1      request; sampled only in IDLE
- a        input   WIDTH  operand A; captured on accepted start
- b        input   WIDTH  operand B; captured on accepted start
- cin      input   1      carry-in; captured on accepted start
- busy     output  1      high while bits are being processed (RUN)
- done     output  1      one-cycle pulse: result valid and new
- sum      output  WIDTH  registered result
- cout     output  1      registered carry-out of the MSB
- ovf      output  1      registered signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). While rst_n=0:
  - state=IDLE.
  - busy, done, sum, cout and ovf = 0.
  - Internal shift registers, carry FF and counter = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - At an edge with start=1: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN (busy=1): each edge applies a_sh[0], b_sh[0] and carry to the full_adder, then:
  - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by one, with 0 shifted in.
  - carry <= fa_cout.
  - cnt <= cnt+1.
  - When cnt = WIDTH-2, additionally latch msb_cin <= fa_cout (this is the carry into the MSB).
  - When cnt = WIDTH-1 (final bit):
    - sum <= {fa_sum, sum_sh[WIDTH-1:1]}.
    - cout <= fa_cout.
    - ovf <= msb_cin ^ fa_cout.
    - state <= DONE.
- DONE: done=1 and busy=0 for exactly one cycle; the next edge goes unconditionally to IDLE.
- Timing: start sampled at edge t0 →
  - busy=1 from after t0 until edge t0+WIDTH.
  - done=1 between edges t0+WIDTH and t0+WIDTH+1.
  - Minimum start-to-start period is WIDTH+2 cycles.
- sum, cout and ovf change only at the final RUN edge. They hold their value through DONE and IDLE until the next operation completes. Partial results are never visible on sum.
- start in RUN or DONE is ignored, not queued. If start is held high continuously, a new operation is accepted at the first IDLE edge.
- Changes to a, b or cin after acceptance have no effect on the operation in progress.
- Reset asserted mid-RUN or in DONE:
  - Aborts immediately.
  - Outputs clear to 0.
  - No done pulse is produced for the aborted operation.
- Arithmetic: unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- Counter width: $clog2(WIDTH).
- busy and done are never high simultaneously.

Test Plan:
- WIDTH=8, a=0x3C, b=0x05, cin=0, start pulsed one cycle → busy high 8 cycles; done pulse 8 edges after acceptance; sum=0x41, cout=0, ovf=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- WIDTH=8, a=0x00, b=0x00, cin=1 → sum=0x01, cout=0. Toggle a and b every cycle during RUN → result is unchanged.
- start held high with operands fixed at 0x12/0x34 → done pulses every 10 cycles; sum=0x46 each time. Extra start pulses during RUN produce no additional done pulses.
- After a completed op (sum=0x41), start a new op and drop rst_n at the 4th RUN cycle → outputs clear to 0 asynchronously before the next edge; no done pulse. After release, a fresh op completes correctly.
- WIDTH=4, exhaustive a, b in 0..15 and cin in {0,1} → {cout,sum} equals a+b+cin for all 512 cases; ovf matches signed 4-bit overflow.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
// The master raises start with operands; the slave reports busy, then a one-cycle done with the result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder walks a WIDTH-bit operand pair LSB first,
// one bit per clock, and publishes sum/cout/ovf only once the final bit is processed.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// Handshake: start is sampled only in IDLE and is neither queued nor acknowledged otherwise.
// busy is high while bits are processed; done pulses for one cycle when sum/cout/ovf are new.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry, msb_cin;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          // Carry out of bit WIDTH-2 is the carry into the MSB, needed for signed overflow.
          if (cnt == PENULT) msb_cin <= fa_co;
          if (cnt == LAST) begin
            sum_q  <= {fa_s, sum_sh[WIDTH-1:1]};
            cout_q <= fa_co;
            ovf_q  <= msb_cin ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 scenarios plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder_ctrl;
  logic clk;
  logic rst_n;
  logic [1:0] dbg8, dbg4;
  int tests = 0;
  int fails = 0;
  logic [7:0] last_sum;
  logic       last_cout, last_ovf;

  serial_adder_ctrl_if #(.WIDTH(8)) i8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) i4 ();

  serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave), .dbg_state(dbg8));
  serial_adder_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave), .dbg_state(dbg4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; inputs driven and outputs sampled on negedges.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input bit toggle,
                     input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int busy_n;
    bit got;
    @(negedge clk);
    i8.a = ta; i8.b = tb; i8.cin = tc; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    busy_n = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (i8.done) got = 1;
      else begin
        if (i8.busy) busy_n++;
        check({tag, " sum held during run"}, {24'd0, i8.sum}, {24'd0, last_sum});
        if (toggle) begin
          i8.a = ~i8.a; i8.b = ~i8.b; i8.cin = ~i8.cin;
        end
        @(negedge clk);
      end
    end
    check({tag, " done seen"}, {31'd0, got}, 32'd1);
    check({tag, " busy cycles"}, busy_n, 8);
    check({tag, " busy low at done"}, {31'd0, i8.busy}, 32'd0);
    check({tag, " sum"}, {24'd0, i8.sum}, {24'd0, es});
    check({tag, " cout"}, {31'd0, i8.cout}, {31'd0, ec});
    check({tag, " ovf"}, {31'd0, i8.ovf}, {31'd0, eo});
    @(negedge clk);
    check({tag, " done one cycle"}, {31'd0, i8.done}, 32'd0);
    check({tag, " sum held in idle"}, {24'd0, i8.sum}, {24'd0, es});
    last_sum = es; last_cout = ec; last_ovf = eo;
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    logic [4:0] tot;
    logic       eovf;
    bit got;
    tot  = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
    eovf = (ta[3] == tb[3]) && (tot[3] != ta[3]);
    @(negedge clk);
    i4.a = ta; i4.b = tb; i4.cin = tc; i4.start = 1'b1;
    @(negedge clk);
    i4.start = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (i4.done) got = 1;
      else @(negedge clk);
    end
    check("w4 done seen", {31'd0, got}, 32'd1);
    check("w4 cout_sum", {27'd0, i4.cout, i4.sum}, {27'd0, tot});
    check("w4 ovf", {31'd0, i4.ovf}, {31'd0, eovf});
  endtask

  initial begin
    int idx[3];
    int n;
    int ds;
    rst_n = 1'b0;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
    i4.start = 1'b0; i4.a = '0; i4.b = '0; i4.cin = 1'b0;
    last_sum = 8'h00; last_cout = 1'b0; last_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, i8.busy}, 32'd0);
    check("reset done", {31'd0, i8.done}, 32'd0);
    check("reset sum", {24'd0, i8.sum}, 32'd0);
    check("reset cout", {31'd0, i8.cout}, 32'd0);
    check("reset ovf", {31'd0, i8.ovf}, 32'd0);
    check("reset state", {30'd0, dbg8}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle without start", {31'd0, i8.busy}, 32'd0);

    op8(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, "3c+05");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff+01");
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "7f+01");
    op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "80+80");
    op8(8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "0+0+1 toggled");

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    i8.a = 8'h12; i8.b = 8'h34; i8.cin = 1'b0; i8.start = 1'b1;
    n = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      check("held busy/done exclusive", {31'd0, i8.busy & i8.done}, 32'd0);
      if (i8.done) begin
        if (n < 3) idx[n] = k;
        n++;
        check("held sum", {24'd0, i8.sum}, 32'h46);
      end
    end
    check("held pulse count", n, 3);
    check("held period 1", idx[1] - idx[0], 10);
    check("held period 2", idx[2] - idx[1], 10);
    i8.start = 1'b0;
    repeat (12) @(negedge clk);
    check("held back to idle", {31'd0, i8.busy | i8.done}, 32'd0);
    last_sum = 8'h46; last_cout = 1'b0; last_ovf = 1'b0;

    // asynchronous reset in the 4th RUN cycle
    op8(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, "pre-abort");
    @(negedge clk);
    i8.a = 8'h10; i8.b = 8'h20; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy before reset", {31'd0, i8.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, i8.busy}, 32'd0);
    check("abort done", {31'd0, i8.done}, 32'd0);
    check("abort sum", {24'd0, i8.sum}, 32'd0);
    check("abort cout", {31'd0, i8.cout}, 32'd0);
    check("abort ovf", {31'd0, i8.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ds = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (i8.done) ds++;
    end
    check("abort no done pulse", ds, 0);
    last_sum = 8'h00; last_cout = 1'b0; last_ovf = 1'b0;
    op8(8'h0A, 8'h0B, 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, "after abort");

    // exhaustive WIDTH=4
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          op4(4'(x), 4'(y), 1'(c));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
